// File: rtl/ins_fetcher.sv
// Instruction fetch stage: holds the PC, issues word reads, presents one instruction at a time to the decoder.
// Latency: request 1 cycle after entering S_IDLE, dec_valid 1 cycle after mem_done (or after an icache hit).
// Backpressure: dec_stall holds the instruction in S_HOLD; rdy_in=0 freezes every register.
// Optional icache build: define ICACHE_EN (direct-mapped, 2^ICACHE_IDX_BIT one-word lines).
module ins_fetcher #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          ICACHE_IDX_BIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_addr,
    input  logic        dec_stall,
    input  logic [31:0] dec_next_pc,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // The index must leave at least one tag bit and address at least two lines.
    if (ICACHE_IDX_BIT < 1 || ICACHE_IDX_BIT > 29) begin : g_bad_idx
        $error("ins_fetcher: ICACHE_IDX_BIT out of range");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_mem_req;
    logic        w_mem_req_nxt;
    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr_nxt;
    logic        r_dec_valid;
    logic        w_dec_valid_nxt;
    logic [31:0] r_dec_inst;
    logic [31:0] w_dec_inst_nxt;
    logic [31:0] r_dec_addr;
    logic [31:0] w_dec_addr_nxt;
    logic        r_flush_pending;
    logic        w_flush_pending_nxt;

    logic        w_hit;
    logic [31:0] w_hit_dat;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 30 - ICACHE_IDX_BIT;

    logic [LINES-1:0]          r_line_vld;
    logic [TAG_W-1:0]          r_line_tag [LINES];
    logic [31:0]               r_line_dat [LINES];
    logic [ICACHE_IDX_BIT-1:0] w_rd_idx;
    logic [ICACHE_IDX_BIT-1:0] w_wr_idx;
    logic                      w_fill;

    // Lookup uses the PC about to be fetched; fill uses the address actually requested.
    assign w_rd_idx  = r_pc[ICACHE_IDX_BIT+1:2];
    assign w_wr_idx  = r_mem_addr[ICACHE_IDX_BIT+1:2];
    assign w_hit     = r_line_vld[w_rd_idx] && (r_line_tag[w_rd_idx] == r_pc[31:ICACHE_IDX_BIT+2]);
    assign w_hit_dat = r_line_dat[w_rd_idx];
    // Only responses that are delivered to the decoder are cached; flushed ones are dropped.
    assign w_fill    = (r_state == S_WAIT) && mem_done && !rob_clear && !r_flush_pending;

    // Line valid bits: cleared only by reset, set on every fill.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_line_vld <= '0;
        end else if (rdy_in && w_fill) begin
            r_line_vld[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are qualified by r_line_vld so need no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill) begin
            r_line_tag[w_wr_idx] <= r_mem_addr[31:ICACHE_IDX_BIT+2];
            r_line_dat[w_wr_idx] <= mem_data;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_dat = '0;
`endif

    // State register, frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; rob_clear always wins except that an outstanding read must complete.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rob_clear)  w_state_nxt = S_IDLE;
                else if (w_hit) w_state_nxt = S_HOLD;
                else            w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    if (rob_clear || r_flush_pending) w_state_nxt = S_IDLE;
                    else                              w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rob_clear || !dec_stall) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values for each state.
    always_comb begin
        w_pc_nxt            = r_pc;
        w_mem_req_nxt       = r_mem_req;
        w_mem_addr_nxt      = r_mem_addr;
        w_dec_valid_nxt     = r_dec_valid;
        w_dec_inst_nxt      = r_dec_inst;
        w_dec_addr_nxt      = r_dec_addr;
        w_flush_pending_nxt = r_flush_pending;
        case (r_state)
            S_IDLE: begin
                if (rob_clear) begin
                    w_pc_nxt        = rob_new_pc;
                    w_dec_valid_nxt = 1'b0;
                    w_mem_req_nxt   = 1'b0;
                end else if (w_hit) begin
                    w_dec_valid_nxt = 1'b1;
                    w_dec_inst_nxt  = w_hit_dat;
                    w_dec_addr_nxt  = r_pc;
                end else begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_pc;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    w_mem_req_nxt = 1'b0;
                    if (rob_clear || r_flush_pending) begin
                        w_flush_pending_nxt = 1'b0;
                    end else begin
                        w_dec_valid_nxt = 1'b1;
                        w_dec_inst_nxt  = mem_data;
                        w_dec_addr_nxt  = r_pc;
                    end
                end else if (rob_clear) begin
                    // The read is in flight and cannot be cancelled: remember to drop its data.
                    w_flush_pending_nxt = 1'b1;
                end
                if (rob_clear) begin
                    w_pc_nxt        = rob_new_pc;
                    w_dec_valid_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                if (rob_clear) begin
                    w_pc_nxt        = rob_new_pc;
                    w_dec_valid_nxt = 1'b0;
                end else if (!dec_stall) begin
                    w_pc_nxt        = dec_next_pc;
                    w_dec_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_dec_valid_nxt = 1'b0;
                w_mem_req_nxt   = 1'b0;
            end
        endcase
    end

    // Datapath registers, frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pc            <= RESET_PC;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_dec_valid     <= 1'b0;
            r_dec_inst      <= '0;
            r_dec_addr      <= '0;
            r_flush_pending <= 1'b0;
        end else if (rdy_in) begin
            r_pc            <= w_pc_nxt;
            r_mem_req       <= w_mem_req_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
            r_dec_valid     <= w_dec_valid_nxt;
            r_dec_inst      <= w_dec_inst_nxt;
            r_dec_addr      <= w_dec_addr_nxt;
            r_flush_pending <= w_flush_pending_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign dec_valid = r_dec_valid;
    assign dec_inst  = r_dec_inst;
    assign dec_addr  = r_dec_addr;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: per-cycle vectors of inputs and expected registered outputs.
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
// Also builds with ICACHE_EN defined; the tail sequence then expects cache hits.
module tb_ins_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_addr;
    logic        dec_stall;
    logic [31:0] dec_next_pc;
    logic        rob_clear;
    logic [31:0] rob_new_pc;

    int total;
    int bad;

    typedef struct {
        logic        rdy;
        logic        done;
        logic [31:0] data;
        logic        stall;
        logic [31:0] npc;
        logic        clr;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_inst;
        logic [31:0] e_daddr;
    } vec_t;

    vec_t tbl[$];

    ins_fetcher #(
        .RESET_PC       (32'h0000_0000),
        .ICACHE_IDX_BIT (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_addr    (dec_addr),
        .dec_stall   (dec_stall),
        .dec_next_pc (dec_next_pc),
        .rob_clear   (rob_clear),
        .rob_new_pc  (rob_new_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic vec_t V(input logic rdy, input logic done, input logic [31:0] data,
                               input logic stall, input logic [31:0] npc,
                               input logic clr, input logic [31:0] rpc,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_dv, input logic [31:0] e_inst,
                               input logic [31:0] e_daddr);
        vec_t v;
        v.rdy = rdy; v.done = done; v.data = data; v.stall = stall; v.npc = npc;
        v.clr = clr; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_dv = e_dv; v.e_inst = e_inst; v.e_daddr = e_daddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".mem_req"},   {31'd0, mem_req},   {31'd0, v.e_req});
        chk({tag, ".mem_addr"},  mem_addr,           v.e_addr);
        chk({tag, ".dec_valid"}, {31'd0, dec_valid}, {31'd0, v.e_dv});
        chk({tag, ".dec_inst"},  dec_inst,           v.e_inst);
        chk({tag, ".dec_addr"},  dec_addr,           v.e_addr == v.e_addr ? v.e_daddr : v.e_daddr);
    endtask

    // Drive one vector for one rising edge, then check; returns on the next falling edge.
    task automatic apply(input string tag, input vec_t v);
        rdy_in      = v.rdy;
        mem_done    = v.done;
        mem_data    = v.data;
        dec_stall   = v.stall;
        dec_next_pc = v.npc;
        rob_clear   = v.clr;
        rob_new_pc  = v.rpc;
        @(posedge clk_in);
        #1;
        check_outs(tag, v);
        @(negedge clk_in);
    endtask

    initial begin
        vec_t rv;
        total = 0;
        bad   = 0;
        rst_in = 1'b1; rdy_in = 1'b1; mem_done = 1'b0; mem_data = '0;
        dec_stall = 1'b0; dec_next_pc = '0; rob_clear = 1'b0; rob_new_pc = '0;

        //             rdy done data          stl npc    clr rpc      req addr   dv inst          daddr
        // First fetch of 0: request one cycle after reset, data three cycles later.
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h0,  0, 32'h0,        32'h0));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h0,  0, 32'h0,        32'h0));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h0,  0, 32'h0,        32'h0));
        tbl.push_back(V(1, 1, 32'h13,        0, 32'h0,  0, 32'h0,    0, 32'h0,  1, 32'h13,       32'h0));
        // Decoder stalls five cycles: instruction held, no new request.
        for (int i = 0; i < 5; i++)
            tbl.push_back(V(1, 0, 32'h0,     1, 32'h0,  0, 32'h0,    0, 32'h0,  1, 32'h13,       32'h0));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h40, 0, 32'h0,    0, 32'h0,  0, 32'h13,       32'h0));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h40, 0, 32'h13,       32'h0));
        tbl.push_back(V(1, 1, 32'hAAAA0001,  0, 32'h0,  0, 32'h0,    0, 32'h40, 1, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h8,  0, 32'h0,    0, 32'h40, 0, 32'hAAAA0001, 32'h40));
        // Redirect while waiting on 0x8: request held, response dropped, then fetch 0x100.
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h8,  0, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  1, 32'h100,  1, 32'h8,  0, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h8,  0, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 1, 32'hDEAD,      0, 32'h0,  0, 32'h0,    0, 32'h8,  0, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h100,0, 32'hAAAA0001, 32'h40));
        tbl.push_back(V(1, 1, 32'h0BEEF000,  0, 32'h0,  0, 32'h0,    0, 32'h100,1, 32'h0BEEF000, 32'h100));
        // Redirect coincides with accept: redirect target wins over dec_next_pc.
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h44, 1, 32'h200,  0, 32'h100,0, 32'h0BEEF000, 32'h100));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h200,0, 32'h0BEEF000, 32'h100));
        // Redirect coincides with mem_done: data dropped, next fetch from new target.
        tbl.push_back(V(1, 1, 32'h5555,      0, 32'h0,  1, 32'h300,  0, 32'h200,0, 32'h0BEEF000, 32'h100));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h300,0, 32'h0BEEF000, 32'h100));
        // rdy_in low for three cycles mid-wait: inputs ignored, everything frozen.
        tbl.push_back(V(0, 1, 32'h77,        0, 32'h0,  0, 32'h0,    1, 32'h300,0, 32'h0BEEF000, 32'h100));
        tbl.push_back(V(0, 0, 32'h0,         0, 32'h0,  1, 32'h999,  1, 32'h300,0, 32'h0BEEF000, 32'h100));
        tbl.push_back(V(0, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h300,0, 32'h0BEEF000, 32'h100));
        tbl.push_back(V(1, 1, 32'h12345678,  0, 32'h0,  0, 32'h0,    0, 32'h300,1, 32'h12345678, 32'h300));
        // Redirect out of S_HOLD while stalled, then again in S_IDLE (no request raised).
        tbl.push_back(V(1, 0, 32'h0,         1, 32'h0,  1, 32'h10,   0, 32'h300,0, 32'h12345678, 32'h300));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  1, 32'h20,   0, 32'h300,0, 32'h12345678, 32'h300));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h0,  0, 32'h0,    1, 32'h20, 0, 32'h12345678, 32'h300));
        tbl.push_back(V(1, 1, 32'hCAFE0013,  0, 32'h0,  0, 32'h0,    0, 32'h20, 1, 32'hCAFE0013, 32'h20));
        tbl.push_back(V(1, 0, 32'h0,         0, 32'h20, 0, 32'h0,    0, 32'h20, 0, 32'hCAFE0013, 32'h20));

        // Reset state while rst_in is held.
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rv = V(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
        check_outs("reset", rv);
        @(negedge clk_in);
        rst_in = 1'b0;

        foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

        // Refetch of 0x20: cached build hits with no request, plain build goes to memory.
`ifdef ICACHE_EN
        apply("t_hit20",  V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0, 32'h20, 1, 32'hCAFE0013, 32'h20));
`else
        apply("t_req20",  V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 1, 32'h20, 0, 32'hCAFE0013, 32'h20));
        apply("t_done20", V(1, 1, 32'hCAFE0013, 0, 32'h0, 0, 32'h0, 0, 32'h20, 1, 32'hCAFE0013, 32'h20));
`endif
        // Loop on 0x0 twice; line 0 was overwritten by 0x300, so the first pass misses.
        apply("t_acc0",   V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0, 32'h20, 0, 32'hCAFE0013, 32'h20));
        apply("t_req0",   V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 1, 32'h0,  0, 32'hCAFE0013, 32'h20));
        apply("t_done0",  V(1, 1, 32'h13,       0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h13,       32'h0));
        apply("t_loop0",  V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h13,       32'h0));
`ifdef ICACHE_EN
        apply("t_hit0",   V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h13,       32'h0));
`else
        apply("t_req0b",  V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 1, 32'h0,  0, 32'h13,       32'h0));
        apply("t_done0b", V(1, 1, 32'h13,       0, 32'h0, 0, 32'h0, 0, 32'h0,  1, 32'h13,       32'h0));
`endif
        apply("t_acc4",   V(1, 0, 32'h0,        0, 32'h4, 0, 32'h0, 0, 32'h0,  0, 32'h13,       32'h0));
        apply("t_req4",   V(1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 1, 32'h4,  0, 32'h13,       32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
